fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl.sv | 240 ++++++++++++++++++++++++
 tb/tb_fetch_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_ctrl -- instruction fetch stage controller with IF/ID register.
//
// Issues one instruction-memory read at a time, places the returned word in
// the IF/ID register (instd/pcd/pc4d/validd) and handles decode back-pressure
// through a one-entry skid buffer. Branch/jump redirects from EX discard any
// in-flight response and restart fetch at the (word-aligned) target.
//
// Parameters:
//   RESET_PC   first fetch address after reset
//   NOP_INST   value presented on instd while IF/ID holds no instruction
//
// Ports:
//   clk, rst          clock (rising edge) and asynchronous active-high reset
//   pcsrce, pctargete redirect request and target from EX
//   d_stall           decode holds the IF/ID register this cycle
//   imem_req/addr     read request (single cycle) and address
//   imem_rvalid/rdata read response (single cycle, latency >= 1)
//   instd/pcd/pc4d    IF/ID instruction, its PC and PC+4
//   validd            IF/ID holds a live instruction
//   perf_stall_cnt    cycles with a valid instruction stalled in IF/ID
//   perf_flush_cnt    cycles with a redirect outside reset
//
// Configuration macro: FETCH_PERF_EN -- when defined, the performance
// counters are built (saturating); otherwise both counter ports read 0.
// ---------------------------------------------------------------------------
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h00000000,
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pcsrce,
    input  logic [31:0] pctargete,
    input  logic        d_stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instd,
    output logic [31:0] pcd,
    output logic [31:0] pc4d,
    output logic        validd,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt
);

    typedef enum logic [2:0] {
        ST_RST     = 3'd0,
        ST_FETCH   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_HOLD    = 3'd3,
        ST_DISCARD = 3'd4
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [31:0] pc_r;
    logic [31:0] pc_s;
    logic [31:0] pc_plus4_s;
    logic [31:0] redirect_pc_s;
    logic        redirect_s;
    logic        free_s;

    // The skid buffer only holds the instruction word: while in HOLD the PC
    // has not advanced yet, so pc_r is the buffered word's address.
    logic [31:0] buf_inst_r;
    logic [31:0] buf_inst_s;

    logic        load_s;
    logic [31:0] load_inst_s;

    logic [31:0] instd_r;
    logic [31:0] instd_s;
    logic [31:0] pcd_r;
    logic [31:0] pcd_s;
    logic [31:0] pc4d_r;
    logic [31:0] pc4d_s;
    logic        validd_r;
    logic        validd_s;

    assign pc_plus4_s    = pc_r + 32'd4;
    assign redirect_pc_s = {pctargete[31:2], 2'b00};
    assign redirect_s    = pcsrce & (state_r != ST_RST);
    assign free_s        = ~validd_r | ~d_stall;

    // Next-state, PC, skid buffer and IF/ID next values.
    always_comb begin
        state_s     = state_r;
        pc_s        = pc_r;
        buf_inst_s  = buf_inst_r;
        load_s      = 1'b0;
        load_inst_s = imem_rdata;

        case (state_r)
            ST_RST: begin
                state_s = ST_FETCH;
            end
            ST_FETCH: begin
                if (pcsrce) begin
                    pc_s    = redirect_pc_s;
                    state_s = ST_DISCARD;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (pcsrce) begin
                    pc_s = redirect_pc_s;
                    // A response arriving with the redirect is the stale one;
                    // nothing is left in flight, so fetch can restart now.
                    if (imem_rvalid) begin
                        state_s = ST_FETCH;
                    end else begin
                        state_s = ST_DISCARD;
                    end
                end else if (imem_rvalid) begin
                    if (free_s) begin
                        load_s      = 1'b1;
                        load_inst_s = imem_rdata;
                        pc_s        = pc_plus4_s;
                        state_s     = ST_FETCH;
                    end else begin
                        buf_inst_s = imem_rdata;
                        state_s    = ST_HOLD;
                    end
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_HOLD: begin
                if (pcsrce) begin
                    pc_s    = redirect_pc_s;
                    state_s = ST_FETCH;
                end else if (free_s) begin
                    load_s      = 1'b1;
                    load_inst_s = buf_inst_r;
                    pc_s        = pc_plus4_s;
                    state_s     = ST_FETCH;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            ST_DISCARD: begin
                if (pcsrce) begin
                    pc_s = redirect_pc_s;
                end else begin
                    pc_s = pc_r;
                end
                // The awaited stale response ends the discard even if a new
                // redirect lands in the same cycle; otherwise fetch would
                // wait forever for a second response that never comes.
                if (imem_rvalid) begin
                    state_s = ST_FETCH;
                end else begin
                    state_s = ST_DISCARD;
                end
            end
            default: begin
                state_s = ST_RST;
            end
        endcase

        pcd_s  = pcd_r;
        pc4d_s = pc4d_r;
        if (load_s) begin
            validd_s = 1'b1;
            instd_s  = load_inst_s;
            pcd_s    = pc_r;
            pc4d_s   = pc_plus4_s;
        end else if (redirect_s || !(validd_r && d_stall)) begin
            // Redirect flushes regardless of d_stall; otherwise the entry is
            // consumed (or was already empty) and the NOP is presented.
            validd_s = 1'b0;
            instd_s  = NOP_INST;
        end else begin
            validd_s = 1'b1;
            instd_s  = instd_r;
        end
    end

    // State, PC, skid buffer and IF/ID registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_RST;
            pc_r       <= RESET_PC;
            buf_inst_r <= NOP_INST;
            instd_r    <= NOP_INST;
            pcd_r      <= 32'h00000000;
            pc4d_r     <= 32'h00000000;
            validd_r   <= 1'b0;
        end else begin
            state_r    <= state_s;
            pc_r       <= pc_s;
            buf_inst_r <= buf_inst_s;
            instd_r    <= instd_s;
            pcd_r      <= pcd_s;
            pc4d_r     <= pc4d_s;
            validd_r   <= validd_s;
        end
    end

    assign imem_req  = (state_r == ST_FETCH);
    assign imem_addr = pc_r;
    assign instd     = instd_r;
    assign pcd       = pcd_r;
    assign pc4d      = pc4d_r;
    assign validd    = validd_r;

`ifdef FETCH_PERF_EN
    logic [31:0] stall_cnt_r;
    logic [31:0] flush_cnt_r;

    // Saturating performance counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_r <= 32'h00000000;
            flush_cnt_r <= 32'h00000000;
        end else begin
            if (validd_r && d_stall && (stall_cnt_r != 32'hFFFFFFFF)) begin
                stall_cnt_r <= stall_cnt_r + 32'd1;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (redirect_s && (flush_cnt_r != 32'hFFFFFFFF)) begin
                flush_cnt_r <= flush_cnt_r + 32'd1;
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    assign perf_stall_cnt = stall_cnt_r;
    assign perf_flush_cnt = flush_cnt_r;
`else
    assign perf_stall_cnt = 32'h00000000;
    assign perf_flush_cnt = 32'h00000000;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fetch_ctrl -- directed self-checking bench for fetch_ctrl.
// u_dut uses default parameters; u_dut2 uses RESET_PC = 32'hFFFFFFFC to
// exercise PC wrap and an asynchronous reset during an outstanding read.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_fetch_ctrl;

    localparam logic [31:0] NOP = 32'h00000013;
`ifdef FETCH_PERF_EN
    localparam logic [31:0] EXP_STALL = 32'd4;
    localparam logic [31:0] EXP_FLUSH = 32'd2;
`else
    localparam logic [31:0] EXP_STALL = 32'd0;
    localparam logic [31:0] EXP_FLUSH = 32'd0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        pcsrce;
    logic [31:0] pctargete;
    logic        d_stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instd;
    logic [31:0] pcd;
    logic [31:0] pc4d;
    logic        validd;
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;

    logic        rst2;
    logic        pcsrce2;
    logic [31:0] pctargete2;
    logic        d_stall2;
    logic        imem_req2;
    logic [31:0] imem_addr2;
    logic        imem_rvalid2;
    logic [31:0] imem_rdata2;
    logic [31:0] instd2;
    logic [31:0] pcd2;
    logic [31:0] pc4d2;
    logic        validd2;
    logic [31:0] perf_stall_cnt2;
    logic [31:0] perf_flush_cnt2;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fetch_ctrl u_dut (
        .clk(clk), .rst(rst), .pcsrce(pcsrce), .pctargete(pctargete),
        .d_stall(d_stall), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instd(instd),
        .pcd(pcd), .pc4d(pc4d), .validd(validd),
        .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
    );

    fetch_ctrl #(.RESET_PC(32'hFFFFFFFC)) u_dut2 (
        .clk(clk), .rst(rst2), .pcsrce(pcsrce2), .pctargete(pctargete2),
        .d_stall(d_stall2), .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_rvalid(imem_rvalid2), .imem_rdata(imem_rdata2), .instd(instd2),
        .pcd(pcd2), .pc4d(pc4d2), .validd(validd2),
        .perf_stall_cnt(perf_stall_cnt2), .perf_flush_cnt(perf_flush_cnt2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; pcsrce = 1'b0; pctargete = 32'h0; d_stall = 1'b0;
        imem_rvalid = 1'b0; imem_rdata = 32'h0;
        rst2 = 1'b1; pcsrce2 = 1'b0; pctargete2 = 32'h0; d_stall2 = 1'b0;
        imem_rvalid2 = 1'b0; imem_rdata2 = 32'h0;
        #1;
        chk("rst_validd", {31'd0, validd}, 32'd0);
        chk("rst_instd", instd, NOP);
        chk("rst_pcd", pcd, 32'h0);
        chk("rst_pc4d", pc4d, 32'h0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_stall_cnt", perf_stall_cnt, 32'h0);
        chk("rst_flush_cnt", perf_flush_cnt, 32'h0);
        step(); step();
        rst = 1'b0;

        // Latency-1 stream, no stalls
        step();
        chk("f0_req", {31'd0, imem_req}, 32'd1);
        chk("f0_addr", imem_addr, 32'h00000000);
        step();
        chk("w0_req", {31'd0, imem_req}, 32'd0);
        imem_rvalid = 1'b1; imem_rdata = 32'h00100093;
        step();
        imem_rvalid = 1'b0;
        chk("i0_valid", {31'd0, validd}, 32'd1);
        chk("i0_instd", instd, 32'h00100093);
        chk("i0_pcd", pcd, 32'h00000000);
        chk("i0_pc4d", pc4d, 32'h00000004);
        chk("f1_req", {31'd0, imem_req}, 32'd1);
        chk("f1_addr", imem_addr, 32'h00000004);
        step();
        chk("w1_valid", {31'd0, validd}, 32'd0);
        chk("w1_instd_nop", instd, NOP);
        imem_rvalid = 1'b1; imem_rdata = 32'h00200113;
        step();
        imem_rvalid = 1'b0;
        chk("i1_instd", instd, 32'h00200113);
        chk("i1_pcd", pcd, 32'h00000004);
        chk("f2_addr", imem_addr, 32'h00000008);

        // Stall 5 cycles while response for addr 8 returns
        d_stall = 1'b1;
        step();
        chk("s_hold_valid", {31'd0, validd}, 32'd1);
        chk("s_hold_instd", instd, 32'h00200113);
        imem_rvalid = 1'b1; imem_rdata = 32'h00300193;
        step();
        imem_rvalid = 1'b0;
        chk("hold_req_a", {31'd0, imem_req}, 32'd0);
        step();
        chk("hold_req_b", {31'd0, imem_req}, 32'd0);
        step();
        chk("hold_req_c", {31'd0, imem_req}, 32'd0);
        step();
        chk("hold_req_d", {31'd0, imem_req}, 32'd0);
        chk("hold_instd_old", instd, 32'h00200113);
        d_stall = 1'b0;
        step();
        chk("i2_valid", {31'd0, validd}, 32'd1);
        chk("i2_instd", instd, 32'h00300193);
        chk("i2_pcd", pcd, 32'h00000008);
        chk("i2_pc4d", pc4d, 32'h0000000C);
        chk("f3_addr", imem_addr, 32'h0000000C);
        step();
        chk("i2_once", {31'd0, validd}, 32'd0);

        // Redirect in WAIT, stale response at latency 3
        pcsrce = 1'b1; pctargete = 32'h00000103;
        step();
        pcsrce = 1'b0;
        chk("rd_valid", {31'd0, validd}, 32'd0);
        chk("disc_req_a", {31'd0, imem_req}, 32'd0);
        step();
        chk("disc_req_b", {31'd0, imem_req}, 32'd0);
        imem_rvalid = 1'b1; imem_rdata = 32'hDEADBEEF;
        step();
        imem_rvalid = 1'b0;
        chk("rd_req", {31'd0, imem_req}, 32'd1);
        chk("rd_addr", imem_addr, 32'h00000100);
        chk("stale_dropped", {31'd0, validd}, 32'd0);
        step();
        imem_rvalid = 1'b1; imem_rdata = 32'h00400213;
        step();
        imem_rvalid = 1'b0;
        chk("b0_instd", instd, 32'h00400213);
        chk("b0_pcd", pcd, 32'h00000100);
        chk("b0_pc4d", pc4d, 32'h00000104);

        // Redirect coincident with rvalid, d_stall high
        d_stall = 1'b1;
        step();
        chk("c_valid_pre", {31'd0, validd}, 32'd1);
        imem_rvalid = 1'b1; imem_rdata = 32'hBAD0BAD0;
        pcsrce = 1'b1; pctargete = 32'h00000200;
        step();
        imem_rvalid = 1'b0; pcsrce = 1'b0; d_stall = 1'b0;
        chk("c_valid_clr", {31'd0, validd}, 32'd0);
        chk("c_instd_nop", instd, NOP);
        chk("c_req", {31'd0, imem_req}, 32'd1);
        chk("c_addr", imem_addr, 32'h00000200);
        step();
        imem_rvalid = 1'b1; imem_rdata = 32'h00500293;
        step();
        imem_rvalid = 1'b0;
        chk("c0_instd", instd, 32'h00500293);
        chk("c0_pcd", pcd, 32'h00000200);

        // Performance counters: 4 stalled-valid cycles, 2 redirects
        rst = 1'b1;
        #1;
        chk("rst1_async_valid", {31'd0, validd}, 32'd0);
        step();
        rst = 1'b0;
        step();
        chk("p_f0_addr", imem_addr, 32'h00000000);
        step();
        imem_rvalid = 1'b1; imem_rdata = 32'h00600313;
        step();
        imem_rvalid = 1'b0;
        chk("p_d0_instd", instd, 32'h00600313);
        d_stall = 1'b1;
        step(); step(); step(); step();
        chk("p_instd_held", instd, 32'h00600313);
        d_stall = 1'b0;
        pcsrce = 1'b1; pctargete = 32'h00000040;
        step();
        pctargete = 32'h00000083;
        step();
        pcsrce = 1'b0;
        chk("perf_stall", perf_stall_cnt, EXP_STALL);
        chk("perf_flush", perf_flush_cnt, EXP_FLUSH);
        chk("disc_redir_req", {31'd0, imem_req}, 32'd0);
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD0001;
        step();
        imem_rvalid = 1'b0;
        chk("disc_redir_addr", imem_addr, 32'h00000080);
        chk("disc_redir_valid", {31'd0, validd}, 32'd0);

        // RESET_PC = FFFFFFFC: wrap, then async reset during WAIT
        rst2 = 1'b0;
        step();
        chk("w_f0_req", {31'd0, imem_req2}, 32'd1);
        chk("w_f0_addr", imem_addr2, 32'hFFFFFFFC);
        step();
        imem_rvalid2 = 1'b1; imem_rdata2 = 32'h00700393;
        step();
        imem_rvalid2 = 1'b0;
        chk("w_instd", instd2, 32'h00700393);
        chk("w_pcd", pcd2, 32'hFFFFFFFC);
        chk("w_pc4d", pc4d2, 32'h00000000);
        chk("w_f1_addr", imem_addr2, 32'h00000000);
        step();
        rst2 = 1'b1;
        #1;
        chk("ar_valid", {31'd0, validd2}, 32'd0);
        chk("ar_instd", instd2, NOP);
        chk("ar_pcd", pcd2, 32'h0);
        chk("ar_pc4d", pc4d2, 32'h0);
        chk("ar_req", {31'd0, imem_req2}, 32'd0);
        step();
        imem_rvalid2 = 1'b1; imem_rdata2 = 32'hBADBAD00;
        rst2 = 1'b0;
        step();
        imem_rvalid2 = 1'b0;
        chk("ar_restart_req", {31'd0, imem_req2}, 32'd1);
        chk("ar_restart_addr", imem_addr2, 32'hFFFFFFFC);
        chk("ar_late_ignored", {31'd0, validd2}, 32'd0);
        step();
        imem_rvalid2 = 1'b1; imem_rdata2 = 32'h00800413;
        step();
        imem_rvalid2 = 1'b0;
        chk("ar_instd", instd2, 32'h00800413);
        chk("ar_pcd2", pcd2, 32'hFFFFFFFC);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
